// File: rtl/digiota_pkg.sv
// Shared defaults and width helpers for the comparator-bitstream decimator family.
package digiota_pkg;

    localparam int WIN_LOG2_DEF    = 6;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FULL_SCALE_DEF  = 1 << WIN_LOG2_DEF;

    // One extra bit so a window of all ones (2^win_log2) still fits.
    function automatic int out_width(input int win_log2);
        return win_log2 + 1;
    endfunction

endpackage

// File: rtl/digiota_sync.sv
// Plain flop-chain synchronizer for an asynchronous single-bit input; latency STAGES cycles, no backpressure.
module digiota_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/digiota_decimator.sv
// Ones-count decimator over 2^WIN_LOG2 enabled cycles; sample 1 cycle after window end; DIGIOTA_GLITCH_FILT_EN adds a majority filter.
// Backpressure: one-deep output register; a window completing while it is full and not accepted is dropped and flagged as overrun.
module digiota_decimator
    import digiota_pkg::*;
#(
    parameter int WIN_LOG2    = WIN_LOG2_DEF,
    parameter int OUT_W       = out_width(WIN_LOG2),
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmp_in,
    output logic [OUT_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             ovr_pulse,
    output logic             ovr_sticky,
    input  logic             ovr_clr
);

    localparam logic [WIN_LOG2-1:0] WCNT_ONE = {{(WIN_LOG2-1){1'b0}}, 1'b1};

    logic                s;
    logic                b;
    logic [WIN_LOG2-1:0] wcnt;
    logic [OUT_W-1:0]    acc;
    logic [OUT_W-1:0]    win_result;
    logic                tc;
    logic                load;
    logic                drop;

    digiota_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (s)
    );

`ifdef DIGIOTA_GLITCH_FILT_EN
    logic tap1;
    logic tap2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap1 <= 1'b0;
            tap2 <= 1'b0;
        end else begin
            tap1 <= s;
            tap2 <= tap1;
        end
    end

    assign b = (s & tap1) | (s & tap2) | (tap1 & tap2);
`else
    assign b = s;
`endif

    assign tc         = ena && (wcnt == '1);
    assign win_result = acc + {{(OUT_W-1){1'b0}}, b};
    assign load       = tc && (!sample_valid || sample_ready);
    assign drop       = tc && sample_valid && !sample_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            acc  <= '0;
        end else if (ena) begin
            wcnt <= wcnt + WCNT_ONE;
            acc  <= tc ? '0 : win_result;
        end
    end

    // A load on the same cycle as a transfer keeps valid high with fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else if (load) begin
            sample_data  <= win_result;
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_pulse  <= 1'b0;
            ovr_sticky <= 1'b0;
        end else begin
            ovr_pulse  <= drop;
            ovr_sticky <= drop | (ovr_sticky & ~ovr_clr);
        end
    end

endmodule

// File: tb/tb_digiota_decimator.sv
// Directed bench for digiota_decimator at WIN_LOG2=6, SYNC_STAGES=2.
module tb_digiota_decimator;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       cmp_in;
    logic [6:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       ovr_pulse;
    logic       ovr_sticky;
    logic       ovr_clr;

    int asserts = 0;
    int fails   = 0;
    bit toggle  = 1'b0;
    int n;
    int pulses;

`ifdef DIGIOTA_GLITCH_FILT_EN
    localparam int GLITCH_EXP = 0;
`else
    localparam int GLITCH_EXP = 1;
`endif

    digiota_decimator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .cmp_in       (cmp_in),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .ovr_pulse    (ovr_pulse),
        .ovr_sticky   (ovr_sticky),
        .ovr_clr      (ovr_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until sample_valid is seen; n is the number of clock edges taken.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            step();
            if (toggle) cmp_in = ~cmp_in;
            cnt++;
        end while (!sample_valid && cnt < 200);
        if (!sample_valid) chk("wait_valid_timeout", {31'd0, sample_valid}, 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        ena          = 1'b1;
        cmp_in       = 1'b1;
        sample_ready = 1'b1;
        ovr_clr      = 1'b0;
        #1;
        chk("rst_data",   sample_data,  0);
        chk("rst_valid",  sample_valid, 0);
        chk("rst_pulse",  ovr_pulse,    0);
        chk("rst_sticky", ovr_sticky,   0);
        repeat (2) step();
        rst_n = 1'b1;

        // Constant ones: first window loses two cycles to sync fill.
        wait_valid(n);
        chk("ones_w1_cycles", n, 64);
        chk("ones_w1_data", sample_data, 62);
        wait_valid(n);
        chk("ones_w2_cycles", n, 64);
        chk("ones_w2_data", sample_data, 64);
        wait_valid(n);
        chk("ones_w3_cycles", n, 64);
        chk("ones_w3_data", sample_data, 64);
        chk("ones_no_pulse", ovr_pulse, 0);
        chk("ones_no_sticky", ovr_sticky, 0);

        // 50% toggling; first window still sees two trailing ones from the chain.
        cmp_in = 1'b0;
        toggle = 1'b1;
        wait_valid(n);
        chk("tog_w1_data", sample_data, 33);
        wait_valid(n);
        chk("tog_w2_cycles", n, 64);
        chk("tog_w2_data", sample_data, 32);
        toggle = 1'b0;
        cmp_in = 1'b1;
        wait_valid(n);
        chk("tog_exit_data", sample_data, 63);

        // Backpressure over three windows; clear collides with second overrun.
        step();
        sample_ready = 1'b0;
        wait_valid(n);
        chk("bp_first_cycles", n, 63);
        chk("bp_first_data", sample_data, 64);
        pulses = 0;
        for (int i = 1; i <= 128; i++) begin
            step();
            if (ovr_pulse) pulses++;
            if (i == 64) ovr_clr = 1'b1;
            if (i == 65) chk("bp_sticky_cleared", ovr_sticky, 0);
        end
        chk("bp_pulse_count", pulses, 2);
        chk("bp_sticky_set_wins", ovr_sticky, 1);
        chk("bp_held_data", sample_data, 64);
        chk("bp_held_valid", sample_valid, 1);
        step();
        ovr_clr = 1'b0;
        chk("bp_sticky_clr", ovr_sticky, 0);
        sample_ready = 1'b1;
        step();
        chk("bp_transfer", sample_valid, 0);

        // Enable stall of 10 cycles mid-window.
        repeat (20) step();
        ena = 1'b0;
        repeat (10) step();
        ena = 1'b1;
        wait_valid(n);
        chk("stall_cycles", n, 42);
        chk("stall_data", sample_data, 64);

        // Asynchronous reset at wcnt=30 with a held sample.
        sample_ready = 1'b0;
        repeat (30) step();
        chk("prereset_valid", sample_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", sample_data, 0);
        chk("arst_valid", sample_valid, 0);
        chk("arst_sticky", ovr_sticky, 0);
        #2 rst_n = 1'b1;
        sample_ready = 1'b1;
        wait_valid(n);
        chk("postrst_cycles", n, 64);
        chk("postrst_data", sample_data, 62);

        // One single-cycle glitch in an otherwise-zero window.
        cmp_in = 1'b0;
        wait_valid(n);
        chk("zero_flush_cycles", n, 64);
        repeat (10) step();
        cmp_in = 1'b1;
        step();
        cmp_in = 1'b0;
        wait_valid(n);
        chk("glitch_cycles", n, 53);
        chk("glitch_data", sample_data, GLITCH_EXP);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
